// File: rtl/axi_rd_pkg.sv
// Shared constants for the AXI read burst scheduler: FSM encodings and
// AXI burst geometry for fixed 8-byte beats.
package axi_rd_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CALC  = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam int BYTES_PER_BEAT = 8;
   localparam int BEAT_SHIFT     = 3;
   localparam int PAGE_BYTES     = 4096;

   localparam logic [2:0] ARSIZE_8B    = 3'b011;
   localparam logic [1:0] ARBURST_INCR = 2'b01;

endpackage

// File: rtl/axi_read_chunk_calc.sv
// Combinational chunk sizer: the largest legal burst, limited by the remaining
// beats, the per-burst cap and the distance to the next 4 KB page boundary.
module axi_read_chunk_calc
   import axi_rd_pkg::*;
#(
   parameter int REM_WIDTH       = 13,
   parameter int MAX_BURST_BEATS = 16
) (
   input  logic [8:0]           addr_beat,
   input  logic [REM_WIDTH-1:0] rem_beats,
   output logic [REM_WIDTH-1:0] beats
);

   localparam logic [9:0] PAGE_BEATS = 10'(PAGE_BYTES / BYTES_PER_BEAT);

   logic [9:0]           page_beats;
   logic [REM_WIDTH-1:0] page_ext;

   // addr_beat is the beat index within the page, so 1..512 beats remain in it
   always_comb begin
      page_beats = PAGE_BEATS - {1'b0, addr_beat};
      page_ext   = REM_WIDTH'(page_beats);
      beats      = REM_WIDTH'(MAX_BURST_BEATS);
      if (rem_beats < beats) beats = rem_beats;
      if (page_ext < beats)  beats = page_ext;
   end

endmodule

// File: rtl/axi_read_burst_scheduler.sv
// Splits a large read descriptor into 4 KB-safe INCR bursts for the single-burst
// read engine, issuing one chunk at a time and tracking the BRAM beat offset.
module axi_read_burst_scheduler
   import axi_rd_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 64,
   parameter int MAX_BURST_BEATS    = 16,
   parameter int LEN_WIDTH          = 16
) (
   input  logic                          m_axi_aclk,
   input  logic                          m_axi_areset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]          req_len,
   input  logic                          abort,
   output logic                          eng_run,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] eng_addr,
   output logic [9:0]                    eng_len,
   input  logic                          eng_done,
   output logic [LEN_WIDTH-4:0]          bram_base,
   output logic                          busy,
   output logic                          done,
   output logic [LEN_WIDTH-4:0]          done_beats,
   output logic                          aborted
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int BW = LEN_WIDTH - BEAT_SHIFT;

   logic [2:0]    state;
   logic [AW-1:0] addr;
   logic [BW-1:0] rem_beats;
   logic [BW-1:0] cur_beats;
   logic [BW-1:0] calc_beats;
   logic [BW-1:0] rem_next;
   logic          abort_seen;
   logic          unused_ok;

   assign unused_ok = ^{req_addr[2:0], req_len[2:0]};

   assign req_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign eng_run   = (state == ST_ISSUE);
   assign rem_next  = rem_beats - cur_beats;

   axi_read_chunk_calc #(
      .REM_WIDTH       (BW),
      .MAX_BURST_BEATS (MAX_BURST_BEATS)
   ) u_chunk_calc (
      .addr_beat (addr[11:3]),
      .rem_beats (rem_beats),
      .beats     (calc_beats)
   );

   // Abort is sticky from acceptance onward and only takes effect between chunks,
   // so an issued burst always runs to completion.
   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         state      <= ST_IDLE;
         addr       <= '0;
         rem_beats  <= '0;
         cur_beats  <= '0;
         abort_seen <= 1'b0;
         eng_addr   <= '0;
         eng_len    <= '0;
         bram_base  <= '0;
         done_beats <= '0;
         aborted    <= 1'b0;
      end else begin
         if (abort && state != ST_IDLE) abort_seen <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  addr       <= {req_addr[AW-1:3], 3'b000};
                  rem_beats  <= req_len[LEN_WIDTH-1:3];
                  bram_base  <= '0;
                  done_beats <= '0;
                  aborted    <= 1'b0;
                  abort_seen <= abort;
                  state      <= (req_len[LEN_WIDTH-1:3] == '0) ? ST_DONE : ST_CALC;
               end
            end
            ST_CALC: begin
               cur_beats <= calc_beats;
               eng_addr  <= addr;
               eng_len   <= 10'({calc_beats, 3'b000});
               state     <= ST_ISSUE;
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: begin
               if (eng_done) begin
                  addr       <= addr + (AW'(cur_beats) << BEAT_SHIFT);
                  rem_beats  <= rem_next;
                  bram_base  <= bram_base + cur_beats;
                  done_beats <= done_beats + cur_beats;
                  if (rem_next == '0) begin
                     state <= ST_DONE;
                  end else if (abort_seen || abort) begin
                     aborted <= 1'b1;
                     state   <= ST_DONE;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
